timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Avalon-MM master that sequences the 16-bit interval timer peripheral (s1 slave: address[2:0], chipselect, write_n, writedata, readdata, irq) to run a stopwatch.
- Starts the timer in continuous mode with interrupt enabled and acknowledges each timeout.
- Keeps seconds/minutes counters and stops the timer on command.
- Sits between user controls (push-button pulses) and the timer core; replaces software IRQ handling.

Parameters:
SEC_WRAP, 60, seconds counter modulus (2..64)
MIN_WRAP, 60, minutes counter modulus (2..64)

Ports:
clk  in  1  system clock; timer peripheral on same clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  single-cycle start request
cmd_stop  in  1  single-cycle stop request
cmd_clear  in  1  single-cycle clear of seconds/minutes
tmr_address  out  3  timer register address
tmr_chipselect  out  1  timer chipselect
tmr_write_n  out  1  timer write strobe, active-low
tmr_writedata  out  16  timer write data
tmr_readdata  in  16  timer read data, valid the cycle after the read cycle
tmr_irq  in  1  timer timeout interrupt, level
seconds  out  6  elapsed seconds, 0..SEC_WRAP-1
minutes  out  6  elapsed minutes, 0..MIN_WRAP-1
running  out  1  1 while in RUN
tick  out  1  one-cycle pulse per acknowledged timeout
busy  out  1  1 in any state other than IDLE/RUN

Behaviour:
Bus rules:
- Every bus access lasts exactly one cycle.
- Write: chipselect=1, write_n=0.
- Read: chipselect=1, write_n=1.
- Idle: chipselect=0, write_n=1, address=0, writedata=0.
- Bus outputs are a Moore decode of the FSM state; while reset=1 they are forced to idle.

Reset:
- FSM enters W_STOP; seconds=0, minutes=0, tick=0, running=0, stop_pending=0.
- busy reads 1 immediately.
- The timer is therefore always stopped and cleared after our reset, even if the peripheral was not reset.

FSM states:
- IDLE: bus idle. cmd_start and not cmd_stop -> W_START. Otherwise stay; cmd_stop alone is ignored.
- W_START: write addr 1, data 0x0007 (START|CONT|ITO) -> RUN.
- RUN: running=1. tmr_irq=1 -> W_ACK, and counters increment on this edge; irq takes priority over a same-cycle cmd_stop, which is latched into stop_pending. Else cmd_stop -> W_STOP. cmd_start ignored.
- W_ACK: write addr 0, data 0x0000 (clear TO) -> RD_STAT.
- RD_STAT: read addr 0 -> CHK.
- CHK: sample tmr_readdata[0] (TO).
  - TO=1: ack failed -> W_ACK; no further increment (retry loop, unbounded).
  - TO=0 and stop_pending -> W_STOP.
  - TO=0 and not stop_pending -> RUN.
- W_STOP: write addr 1, data 0x0008 (STOP, CONT=0, ITO=0) -> W_SCLR.
- W_SCLR: write addr 0, data 0x0000 -> IDLE; clears stop_pending.

stop_pending:
- Set by cmd_stop in W_ACK, RD_STAT, CHK, or coincident with irq in RUN.
- Cleared in W_SCLR and by reset.

tick:
- Registered; asserted the cycle the FSM is in W_ACK having come from RUN.
- Not asserted on the retry path.

Counter arithmetic (on the RUN->W_ACK edge):
- seconds == SEC_WRAP-1: seconds <= 0; minutes <= (minutes == MIN_WRAP-1) ? 0 : minutes+1.
- Else: seconds <= seconds+1.
- Counters hold in all other states.

cmd_clear:
- Zeroes seconds and minutes in any state.
- Clear wins over a same-cycle increment.
- Does not affect the FSM or the timer.

Latency:
- cmd_start to the start write on the bus: 1 cycle.
- irq to the status-clear write: 1 cycle.
- Nominal timeout handling: 4 cycles (RUN->W_ACK->RD_STAT->CHK->RUN).

Reset mid-operation:
- Abandons any access; the next cycle after reset deasserts performs the W_STOP write.

Test Plan:
1. Reset released -> cycle 1: write addr1 0x0008; cycle 2: write addr0 0x0000; cycle 3: IDLE, busy=0, seconds=minutes=0.
2. cmd_start, then tmr_irq held until the addr0 write -> write addr1 0x0007, running=1. Per irq: tick pulse, write addr0, read addr0. With readdata=0x0002 at CHK: back to RUN, seconds=1.
3. 59 timeouts from seconds=0, minutes=0, then one more -> seconds=0, minutes=1. Preload minutes=59, seconds=59, one timeout -> both 0.
4. readdata[0]=1 at the first CHK -> second addr0 write and read with no extra tick; seconds increments exactly once.
5. cmd_stop during RD_STAT -> CHK goes to W_STOP: writes 0x0008@1 then 0x0000@0, IDLE, running=0. cmd_stop and irq in the same RUN cycle -> tick counted, then stop sequence.
6. cmd_clear coincident with the RUN->W_ACK edge at seconds=5 -> seconds=0. cmd_start in RUN and cmd_stop in IDLE -> no bus activity.

Source files
------------

// File: rtl/timer_sequencer.sv
// Avalon-MM master driving a 16-bit interval timer as a stopwatch: starts it, acknowledges
// each timeout in hardware, counts seconds/minutes and stops/clears the timer on command.
module timer_sequencer #(
  parameter int unsigned SEC_WRAP = 60,
  parameter int unsigned MIN_WRAP = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic [5:0]  seconds,
  output logic [5:0]  minutes,
  output logic        running,
  output logic        tick,
  output logic        busy
);

  localparam int unsigned CW = 6;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  localparam logic [AW-1:0] ADDR_STATUS  = AW'(0);
  localparam logic [AW-1:0] ADDR_CONTROL = AW'(1);
  localparam logic [DW-1:0] CTRL_START   = DW'(16'h0007);
  localparam logic [DW-1:0] CTRL_STOP    = DW'(16'h0008);
  localparam logic [DW-1:0] STATUS_CLR   = DW'(16'h0000);

  localparam logic [CW-1:0] SEC_LAST = CW'(SEC_WRAP - 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_WRAP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_START = 3'd1,
    S_RUN     = 3'd2,
    S_W_ACK   = 3'd3,
    S_RD_STAT = 3'd4,
    S_CHK     = 3'd5,
    S_W_STOP  = 3'd6,
    S_W_SCLR  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_seconds;
  logic [CW-1:0]   r_minutes;
  logic            r_tick;
  logic            r_running;
  logic            r_stop_pending;
  logic            w_timeout;
  logic            w_status_to;
  logic            w_stop_req;

  // Only the TO bit steers the FSM; the remaining status bits are folded in as don't-cares.
  assign w_status_to = tmr_readdata[0] | (1'b0 & (^tmr_readdata[DW-1:1]));
  assign w_timeout   = (r_state == S_RUN) && tmr_irq;
  assign w_stop_req  = r_stop_pending || cmd_stop;

  // State register; reset always lands in the stop sequence so the timer ends up quiesced.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_W_STOP;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_start && !cmd_stop) w_next = S_W_START;
      S_W_START: w_next = S_RUN;
      S_RUN: begin
        if (tmr_irq)       w_next = S_W_ACK;
        else if (cmd_stop) w_next = S_W_STOP;
      end
      S_W_ACK:   w_next = S_RD_STAT;
      S_RD_STAT: w_next = S_CHK;
      S_CHK: begin
        if (w_status_to)     w_next = S_W_ACK;
        else if (w_stop_req) w_next = S_W_STOP;
        else                 w_next = S_RUN;
      end
      S_W_STOP:  w_next = S_W_SCLR;
      S_W_SCLR:  w_next = S_IDLE;
      default:   w_next = S_W_STOP;
    endcase
  end

  // Moore bus decode, held idle while reset is asserted.
  always_comb begin
    tmr_address    = '0;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_writedata  = '0;
    if (!reset) begin
      case (r_state)
        S_W_START: begin
          tmr_address    = ADDR_CONTROL;
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_writedata  = CTRL_START;
        end
        S_W_ACK, S_W_SCLR: begin
          tmr_address    = ADDR_STATUS;
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_writedata  = STATUS_CLR;
        end
        S_RD_STAT: begin
          tmr_address    = ADDR_STATUS;
          tmr_chipselect = 1'b1;
        end
        S_W_STOP: begin
          tmr_address    = ADDR_CONTROL;
          tmr_chipselect = 1'b1;
          tmr_write_n    = 1'b0;
          tmr_writedata  = CTRL_STOP;
        end
        default: ;
      endcase
    end
  end

  // Stopwatch counters, status flags and the deferred-stop latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seconds      <= '0;
      r_minutes      <= '0;
      r_tick         <= 1'b0;
      r_running      <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      r_tick    <= w_timeout;
      r_running <= (w_next == S_RUN);

      if (cmd_clear) begin
        r_seconds <= '0;
        r_minutes <= '0;
      end else if (w_timeout) begin
        if (r_seconds == SEC_LAST) begin
          r_seconds <= '0;
          r_minutes <= (r_minutes == MIN_LAST) ? '0 : r_minutes + CW'(1);
        end else begin
          r_seconds <= r_seconds + CW'(1);
        end
      end

      if (r_state == S_W_SCLR)
        r_stop_pending <= 1'b0;
      else if (cmd_stop && (w_timeout || r_state == S_W_ACK ||
                            r_state == S_RD_STAT || r_state == S_CHK))
        r_stop_pending <= 1'b1;
    end
  end

  assign seconds = r_seconds;
  assign minutes = r_minutes;
  assign tick    = r_tick;
  assign running = r_running;
  assign busy    = reset || !((r_state == S_IDLE) || (r_state == S_RUN));

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed scoreboard bench for timer_sequencer: expected bus accesses are queued as stimulus
// is applied and matched against every access the DUT issues; counters follow a small model.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_clear;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;
  logic [5:0]  seconds, minutes;
  logic        running, tick, busy;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  int m_sec = 0;
  int m_min = 0;

  always #5 clk = ~clk;

  timer_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .seconds(seconds), .minutes(minutes),
    .running(running), .tick(tick), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {a, 1'b0, d};
  endfunction

  function automatic logic [19:0] rd(input logic [2:0] a);
    return {a, 1'b1, 16'h0000};
  endfunction

  // Match whatever the bus shows this cycle against the scoreboard.
  task automatic mon();
    logic [19:0] obs;
    obs = {tmr_address, tmr_write_n, tmr_writedata};
    if (tmr_chipselect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL bus_unexpected observed=%0h expected=none", obs);
      end else begin
        chk("bus_access", 32'(obs), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("bus_idle", 32'(obs), 32'({3'd0, 1'b1, 16'h0000}));
    end
  endtask

  // Observe the current cycle, then advance to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc(input bit clr);
    if (clr) begin
      m_sec = 0;
      m_min = 0;
    end else if (m_sec == 59) begin
      m_sec = 0;
      m_min = (m_min == 59) ? 0 : m_min + 1;
    end else begin
      m_sec = m_sec + 1;
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_sec"}, 32'(seconds), 32'(m_sec));
    chk({tag, "_min"}, 32'(minutes), 32'(m_min));
  endtask

  // One timeout from RUN, with `retries` failed acknowledgements before the clean read.
  task automatic timeout(input int retries, input bit clr);
    tmr_irq = 1'b1;
    cmd_clear = clr;
    exp_q.push_back(wr(3'd0, 16'h0000));
    exp_q.push_back(rd(3'd0));
    cyc();
    tmr_irq = 1'b0;
    cmd_clear = 1'b0;
    model_inc(clr);
    chk("tick_on_ack", 32'(tick), 32'd1);
    check_counters("inc");
    for (int r = 0; r <= retries; r++) begin
      tmr_readdata = (r < retries) ? 16'h0001 : 16'h0002;
      cyc();
      chk("tick_pulse_end", 32'(tick), 32'd0);
      cyc();
      cyc();
      if (r < retries) begin
        chk("tick_on_retry", 32'(tick), 32'd0);
        exp_q.push_back(wr(3'd0, 16'h0000));
        exp_q.push_back(rd(3'd0));
      end
    end
    tmr_readdata = 16'h0000;
    chk("running_after_ack", 32'(running), 32'd1);
    check_counters("after_ack");
  endtask

  task automatic start_run();
    cmd_start = 1'b1;
    exp_q.push_back(wr(3'd1, 16'h0007));
    cyc();
    cmd_start = 1'b0;
    chk("busy_in_start", 32'(busy), 32'd1);
    cyc();
    chk("running_in_run", 32'(running), 32'd1);
    chk("busy_in_run", 32'(busy), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    tmr_irq = 1'b0; tmr_readdata = 16'h0000;

    // Reset, then the mandatory stop/clear sequence.
    cyc(); cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    check_counters("rst");
    reset = 1'b0;
    exp_q.push_back(wr(3'd1, 16'h0008));
    exp_q.push_back(wr(3'd0, 16'h0000));
    cyc(); cyc();
    expect_idle("post_rst");
    check_counters("post_rst");

    // Start and first timeout.
    start_run();
    timeout(0, 1'b0);

    // Failed acknowledgement retried once, single increment.
    timeout(1, 1'b0);

    // Clear coincident with the increment edge at seconds=5.
    while (m_sec != 5) timeout(0, 1'b0);
    timeout(0, 1'b1);

    // Seconds rollover into minutes.
    for (int i = 0; i < 60; i++) timeout(0, 1'b0);
    chk("roll_sec", 32'(seconds), 32'd0);
    chk("roll_min", 32'(minutes), 32'd1);

    // Run up to 59:59 and wrap both counters.
    while (!(m_sec == 59 && m_min == 59)) timeout(0, 1'b0);
    timeout(0, 1'b0);
    chk("wrap_sec", 32'(seconds), 32'd0);
    chk("wrap_min", 32'(minutes), 32'd0);

    // cmd_start while running is ignored.
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc(); cyc();
    chk("start_in_run", 32'(running), 32'd1);

    // Stop requested during the status read.
    tmr_irq = 1'b1;
    exp_q.push_back(wr(3'd0, 16'h0000));
    exp_q.push_back(rd(3'd0));
    cyc();
    tmr_irq = 1'b0;
    model_inc(1'b0);
    tmr_readdata = 16'h0002;
    cyc();
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    exp_q.push_back(wr(3'd1, 16'h0008));
    exp_q.push_back(wr(3'd0, 16'h0000));
    cyc();
    chk("stop_busy", 32'(busy), 32'd1);
    cyc(); cyc();
    expect_idle("after_stop");
    check_counters("after_stop");

    // cmd_stop in IDLE is ignored; cmd_clear works outside RUN.
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    cyc(); cyc();
    expect_idle("stop_in_idle");
    cmd_clear = 1'b1;
    cyc();
    cmd_clear = 1'b0;
    model_inc(1'b1);
    check_counters("clear_idle");

    // Stop coinciding with irq: tick counted, then stop sequence.
    start_run();
    tmr_irq = 1'b1;
    cmd_stop = 1'b1;
    exp_q.push_back(wr(3'd0, 16'h0000));
    exp_q.push_back(rd(3'd0));
    exp_q.push_back(wr(3'd1, 16'h0008));
    exp_q.push_back(wr(3'd0, 16'h0000));
    cyc();
    tmr_irq = 1'b0;
    cmd_stop = 1'b0;
    model_inc(1'b0);
    chk("stop_irq_tick", 32'(tick), 32'd1);
    check_counters("stop_irq");
    tmr_readdata = 16'h0002;
    cyc(); cyc(); cyc(); cyc(); cyc();
    expect_idle("after_stop_irq");

    // Reset mid-run abandons the run and replays the stop sequence.
    start_run();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_inc(1'b1);
    exp_q.push_back(wr(3'd1, 16'h0008));
    exp_q.push_back(wr(3'd0, 16'h0000));
    cyc(); cyc();
    expect_idle("mid_rst");
    check_counters("mid_rst");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
